fpu_op_sequencer: RTL and testbench

// Sequences single FP operations through the combinational floating_point_alu for the MIPS core.
// - Accepts one op per request handshake and holds the ALU operands stable for a programmable settle time.
// - Captures the ALU result and exception flags, then presents them on a writeback handshake.
// - Accumulates exceptions into a sticky FCSR-style flag register.

---
 rtl/fpu_op_sequencer.sv | 147 ++++++++++++++
 tb/tb_fpu_op_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_op_sequencer.sv
// Runs one FP operation at a time through the combinational FP ALU, then offers the result on a writeback handshake.
// Exception flags from completed writebacks collect in a sticky FCSR-style register.
//
// state  | meaning
// S_IDLE | ready for a request; falu_* keep the last captured operands
// S_EXEC | operands held on the ALU while the settle counter runs down
// S_WB   | result held on the wb_* outputs until the register file accepts it
module fpu_op_sequencer #(
   parameter int unsigned LATENCY     = 3,
   parameter int unsigned DIV_LATENCY = 6
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [3:0]  req_opcode_i,
   input  logic [31:0] req_a_i,
   input  logic [31:0] req_b_i,
   input  logic [4:0]  req_dest_i,
   output logic [3:0]  falu_opcode_o,
   output logic [31:0] falu_a_o,
   output logic [31:0] falu_b_o,
   input  logic [31:0] falu_result_i,
   input  logic [6:0]  falu_flags_i,
   output logic        wb_valid_o,
   input  logic        wb_ready_i,
   output logic [4:0]  wb_dest_o,
   output logic [31:0] wb_data_o,
   output logic [6:0]  wb_flags_o,
   output logic        illegal_op_o,
   output logic [6:0]  sticky_flags_o,
   input  logic        clear_sticky_i,
   output logic        busy_o
);

   localparam int unsigned MAX_LAT = (LATENCY > DIV_LATENCY) ? LATENCY : DIV_LATENCY;
   localparam int unsigned CNT_W   = $clog2(MAX_LAT) + 1;
   localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);
   localparam logic [CNT_W-1:0] DIV_M1 = CNT_W'(DIV_LATENCY - 1);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       op_q, op_d;
   logic [31:0]      a_q, a_d, b_q, b_d;
   logic [4:0]       dest_q, dest_d;
   logic [4:0]       wb_dest_q, wb_dest_d;
   logic [31:0]      wb_data_q, wb_data_d;
   logic [6:0]       wb_flags_q, wb_flags_d;
   logic             illegal_q, illegal_d;
   logic [6:0]       sticky_q, sticky_d;
   logic             wb_hs;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         op_q       <= '0;
         a_q        <= '0;
         b_q        <= '0;
         dest_q     <= '0;
         wb_dest_q  <= '0;
         wb_data_q  <= '0;
         wb_flags_q <= '0;
         illegal_q  <= 1'b0;
         sticky_q   <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         op_q       <= op_d;
         a_q        <= a_d;
         b_q        <= b_d;
         dest_q     <= dest_d;
         wb_dest_q  <= wb_dest_d;
         wb_data_q  <= wb_data_d;
         wb_flags_q <= wb_flags_d;
         illegal_q  <= illegal_d;
         sticky_q   <= sticky_d;
      end
   end

   assign wb_hs = (state_q == S_WB) && wb_ready_i;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      op_d       = op_q;
      a_d        = a_q;
      b_d        = b_q;
      dest_d     = dest_q;
      wb_dest_d  = wb_dest_q;
      wb_data_d  = wb_data_q;
      wb_flags_d = wb_flags_q;
      illegal_d  = 1'b0;
      // a flag set by the coincident handshake must survive the clear
      sticky_d   = (clear_sticky_i ? 7'b0 : sticky_q) | (wb_hs ? wb_flags_q : 7'b0);

      unique case (state_q)
         S_IDLE: begin
            if (req_valid_i) begin
               op_d   = req_opcode_i;
               a_d    = req_a_i;
               b_d    = req_b_i;
               dest_d = req_dest_i;
               if (req_opcode_i <= 4'd6) begin
                  cnt_d   = ((req_opcode_i == 4'd4) || (req_opcode_i == 4'd5)) ? DIV_M1 : LAT_M1;
                  state_d = S_EXEC;
               end else begin
                  wb_data_d  = '0;
                  wb_flags_d = '0;
                  wb_dest_d  = req_dest_i;
                  illegal_d  = 1'b1;
                  state_d    = S_WB;
               end
            end
         end
         S_EXEC: begin
            if (cnt_q == '0) begin
               wb_data_d  = falu_result_i;
               wb_flags_d = falu_flags_i;
               wb_dest_d  = dest_q;
               state_d    = S_WB;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_WB: begin
            if (wb_ready_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign req_ready_o    = (state_q == S_IDLE);
   assign busy_o         = (state_q != S_IDLE);
   assign wb_valid_o     = (state_q == S_WB);
   assign falu_opcode_o  = op_q;
   assign falu_a_o       = a_q;
   assign falu_b_o       = b_q;
   assign wb_dest_o      = wb_dest_q;
   assign wb_data_o      = wb_data_q;
   assign wb_flags_o     = wb_flags_q;
   assign illegal_op_o   = illegal_q;
   assign sticky_flags_o = sticky_q;

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Directed bench for fpu_op_sequencer with a stub FP ALU; inputs change and outputs are sampled on the falling edge.
module tb_fpu_op_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready;
   logic [3:0]  req_opcode;
   logic [31:0] req_a, req_b;
   logic [4:0]  req_dest;
   logic [3:0]  falu_opcode;
   logic [31:0] falu_a, falu_b, falu_result;
   logic [6:0]  falu_flags;
   logic        wb_valid, wb_ready;
   logic [4:0]  wb_dest;
   logic [31:0] wb_data;
   logic [6:0]  wb_flags;
   logic        illegal_op;
   logic [6:0]  sticky_flags;
   logic        clear_sticky;
   logic        busy;

   logic [6:0]  stub_flags;
   int          n_total = 0;
   int          n_bad   = 0;

   always #5 clk = ~clk;

   fpu_op_sequencer #(.LATENCY(3), .DIV_LATENCY(6)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_valid_i    (req_valid),
      .req_ready_o    (req_ready),
      .req_opcode_i   (req_opcode),
      .req_a_i        (req_a),
      .req_b_i        (req_b),
      .req_dest_i     (req_dest),
      .falu_opcode_o  (falu_opcode),
      .falu_a_o       (falu_a),
      .falu_b_o       (falu_b),
      .falu_result_i  (falu_result),
      .falu_flags_i   (falu_flags),
      .wb_valid_o     (wb_valid),
      .wb_ready_i     (wb_ready),
      .wb_dest_o      (wb_dest),
      .wb_data_o      (wb_data),
      .wb_flags_o     (wb_flags),
      .illegal_op_o   (illegal_op),
      .sticky_flags_o (sticky_flags),
      .clear_sticky_i (clear_sticky),
      .busy_o         (busy)
   );

   // stub ALU: the known add and divide-by-zero cases get fixed answers
   always_comb begin
      falu_result = falu_a ^ falu_b;
      falu_flags  = stub_flags;
      if (falu_opcode == 4'd0 && falu_a == 32'h3F80_0000 && falu_b == 32'h4000_0000) begin
         falu_result = 32'h4040_0000;
         falu_flags  = 7'b0;
      end else if (falu_opcode == 4'd4 && falu_b == 32'h0) begin
         falu_result = 32'h7F80_0000;
         falu_flags  = 7'b000_0010;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // request is presented in cycle T; returns at the falling edge of T+1
   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] d);
      @(negedge clk);
      req_valid = 1'b1; req_opcode = op; req_a = a; req_b = b; req_dest = d;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   // n counts cycles from T+1 up to and including the first wb_valid cycle
   task automatic wait_wb(output int n);
      n = 1;
      while (!wb_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
   endtask

   int  n;
   bit  seen;

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_opcode = '0; req_a = '0; req_b = '0; req_dest = '0;
      wb_ready = 1'b0; clear_sticky = 1'b0; stub_flags = 7'b0;

      // reset
      @(negedge clk);
      chk("rst_ready", req_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_wbv", wb_valid, 0);
      chk("rst_wbdata", wb_data, 0);
      chk("rst_sticky", sticky_flags, 0);
      chk("rst_falu_a", falu_a, 0);
      chk("rst_illegal", illegal_op, 0);
      rst_n = 1'b1;

      // add: L=3, wb_valid at T+4
      @(negedge clk);
      chk("add_ready_T", req_ready, 1);
      req_valid = 1'b1; req_opcode = 4'd0; req_a = 32'h3F80_0000; req_b = 32'h4000_0000; req_dest = 5'd5;
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         req_valid = 1'b0; req_a = 32'h0; req_b = 32'h0;
         chk("add_falu_a", falu_a, 32'h3F80_0000);
         chk("add_falu_b", falu_b, 32'h4000_0000);
         chk("add_ready", req_ready, 0);
         chk("add_wbv_early", wb_valid, 0);
      end
      @(negedge clk);
      chk("add_wbv", wb_valid, 1);
      chk("add_data", wb_data, 32'h4040_0000);
      chk("add_dest", wb_dest, 5);
      chk("add_ready_wb", req_ready, 0);
      wb_ready = 1'b1;
      @(negedge clk);
      wb_ready = 1'b0;
      chk("add_done_wbv", wb_valid, 0);
      chk("add_done_ready", req_ready, 1);
      chk("add_sticky", sticky_flags, 0);

      // divide by zero with backpressure: wb_valid at T+7, held 5 cycles
      issue(4'd4, 32'h3F80_0000, 32'h0, 5'd7);
      wait_wb(n);
      chk("div_latency", n, 7);
      chk("div_wbv", wb_valid, 1);
      chk("div_flags", wb_flags, 7'b000_0010);
      chk("div_data", wb_data, 32'h7F80_0000);
      for (int i = 0; i < 5; i++) begin
         req_valid = 1'b1; req_opcode = 4'd0; req_dest = 5'd1;
         @(negedge clk);
         chk("bp_wbv", wb_valid, 1);
         chk("bp_data", wb_data, 32'h7F80_0000);
         chk("bp_dest", wb_dest, 7);
         chk("bp_ready", req_ready, 0);
      end
      req_valid = 1'b0;
      wb_ready = 1'b1;
      @(negedge clk);
      wb_ready = 1'b0;
      chk("div_done_wbv", wb_valid, 0);
      chk("div_sticky", sticky_flags, 7'b000_0010);
      chk("div_busy", busy, 0);

      // illegal opcode: straight to WB, one-cycle illegal_op pulse
      issue(4'd8, 32'h1234_5678, 32'h9ABC_DEF0, 5'd3);
      chk("ill_pulse", illegal_op, 1);
      chk("ill_wbv", wb_valid, 1);
      chk("ill_data", wb_data, 0);
      chk("ill_flags", wb_flags, 0);
      chk("ill_dest", wb_dest, 3);
      @(negedge clk);
      chk("ill_pulse_end", illegal_op, 0);
      chk("ill_wbv_hold", wb_valid, 1);
      wb_ready = 1'b1;
      @(negedge clk);
      wb_ready = 1'b0;
      chk("ill_done_wbv", wb_valid, 0);
      chk("ill_sticky", sticky_flags, 7'b000_0010);

      // clear on its own, then clear coincident with a handshake
      clear_sticky = 1'b1;
      @(negedge clk);
      clear_sticky = 1'b0;
      chk("clr_alone", sticky_flags, 0);
      stub_flags = 7'b100_0000;
      issue(4'd1, 32'h0000_0001, 32'h0000_0002, 5'd9);
      wait_wb(n);
      chk("sub_latency", n, 4);
      chk("sub_data", wb_data, 32'h0000_0003);
      wb_ready = 1'b1;
      @(negedge clk);
      wb_ready = 1'b0;
      chk("sub_sticky", sticky_flags, 7'b100_0000);
      stub_flags = 7'b000_0001;
      issue(4'd1, 32'h0000_0004, 32'h0000_0001, 5'd10);
      wait_wb(n);
      chk("sub2_flags", wb_flags, 7'b000_0001);
      wb_ready = 1'b1; clear_sticky = 1'b1;
      @(negedge clk);
      wb_ready = 1'b0; clear_sticky = 1'b0;
      chk("clr_coinc", sticky_flags, 7'b000_0001);

      // reset during EXEC at T+2 of an add
      issue(4'd0, 32'h3F80_0000, 32'h4000_0000, 5'd5);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rmid_wbv", wb_valid, 0);
      chk("rmid_busy", busy, 0);
      chk("rmid_sticky", sticky_flags, 0);
      chk("rmid_ready", req_ready, 1);
      chk("rmid_falu_a", falu_a, 0);
      wb_ready = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (wb_valid) seen = 1'b1;
      end
      wb_ready = 1'b0;
      chk("rmid_no_wb", seen, 0);
      chk("rmid_sticky_end", sticky_flags, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
